multicycle_control: RTL and testbench

Moore/Mealy FSM that sequences a shared-memory multi-cycle MIPS datapath, replacing the single-cycle opcode decoder. It is the only block that drives PC, IR, memory and register-file enables. Each instruction executes as a series of states: fetch, decode, execute, memory and writeback. A ready handshake lets instruction/data memory insert wait states. It supports the same opcode set as the single-cycle core plus J and JAL.

---
 rtl/multicycle_pkg.sv | 72 +++++++
 rtl/multicycle_control_output_decode.sv | 115 +++++++++++
 rtl/multicycle_control.sv | 86 ++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared state, opcode and select encodings for the multi-cycle controller
package multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        R_EXEC    = 4'd3,
        R_WB      = 4'd4,
        I_EXEC    = 4'd5,
        I_WB      = 4'd6,
        MEM_ADDR  = 4'd7,
        MEM_READ  = 4'd8,
        MEM_WB    = 4'd9,
        MEM_WRITE = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        ILLEGAL   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_NONE  = 4'b0000;
    localparam logic [3:0] ALU_LW    = 4'b0001;
    localparam logic [3:0] ALU_SW    = 4'b0010;
    localparam logic [3:0] ALU_BR    = 4'b0011;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_ORI   = 4'b0101;
    localparam logic [3:0] ALU_LUI   = 4'b0110;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    // Post-DECODE state for each opcode class.
    function automatic state_t dispatch(input logic [5:0] op);
        state_t s;
        case (op)
            OP_RTYPE:                s = R_EXEC;
            OP_ADDI, OP_ORI, OP_LUI: s = I_EXEC;
            OP_LW, OP_SW:            s = MEM_ADDR;
            OP_BEQ, OP_BNE:          s = BRANCH;
            OP_J, OP_JAL:            s = JUMP;
            default:                 s = ILLEGAL;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// rtl/multicycle_control_output_decode.sv - combinational map from (state, op_q, mem_ready) to control outputs
module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_op_q,
    input  logic        i_mem_ready,
    output logic        o_pc_write,
    output logic        o_branch_eq,
    output logic        o_branch_ne,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic [1:0]  o_mem_to_reg,
    output logic [1:0]  o_reg_dst,
    output logic        o_reg_write,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [3:0]  o_alu_op,
    output logic [1:0]  o_pc_source,
    output logic        o_illegal_op
);

    always_comb begin
        o_pc_write   = 1'b0;
        o_branch_eq  = 1'b0;
        o_branch_ne  = 1'b0;
        o_iord       = 1'b0;
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_ir_write   = 1'b0;
        o_mem_to_reg = M2R_ALUOUT;
        o_reg_dst    = RDST_RT;
        o_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = SRCB_B;
        o_alu_op     = ALU_NONE;
        o_pc_source  = PCSRC_ALU;
        o_illegal_op = 1'b0;
        case (i_state)
            FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = SRCB_FOUR;
                o_alu_op    = ALU_ADD;
                // IR and PC only load once memory has actually returned the word.
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            DECODE: begin
                o_alu_src_b = SRCB_IMM_SH2;
                o_alu_op    = ALU_ADD;
            end
            R_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_RTYPE;
            end
            R_WB: begin
                o_reg_dst   = RDST_RD;
                o_reg_write = 1'b1;
            end
            I_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                case (i_op_q)
                    OP_ORI:  o_alu_op = ALU_ORI;
                    OP_LUI:  o_alu_op = ALU_LUI;
                    default: o_alu_op = ALU_ADD;
                endcase
            end
            I_WB: begin
                o_reg_write = 1'b1;
            end
            MEM_ADDR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = SRCB_IMM;
                o_alu_op    = (i_op_q == OP_SW) ? ALU_SW : ALU_LW;
            end
            MEM_READ: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            MEM_WB: begin
                o_mem_to_reg = M2R_MDR;
                o_reg_write  = 1'b1;
            end
            MEM_WRITE: begin
                o_iord      = 1'b1;
                o_mem_write = 1'b1;
            end
            BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALU_BR;
                o_pc_source = PCSRC_ALUOUT;
                o_branch_eq = (i_op_q == OP_BEQ);
                o_branch_ne = (i_op_q == OP_BNE);
            end
            JUMP: begin
                o_pc_source = PCSRC_JUMP;
                o_pc_write  = 1'b1;
                if (i_op_q == OP_JAL) begin
                    o_reg_dst    = RDST_RA;
                    o_mem_to_reg = M2R_PC;
                    o_reg_write  = 1'b1;
                end
            end
            ILLEGAL: begin
                o_illegal_op = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - state register, latched opcode and next-state logic for the multi-cycle MIPS core
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               BranchEQ,
    output logic               BranchNE,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         MemtoReg,
    output logic [1:0]         RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [3:0]         state_dbg
);

    state_t          r_state;
    state_t          w_next_state;
    logic [OP_W-1:0] r_op_q;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:      w_next_state = FETCH;
            FETCH:     w_next_state = mem_ready ? DECODE : FETCH;
            // Dispatch on the live opcode; op_q captures it on this same edge.
            DECODE:    w_next_state = dispatch(OP);
            R_EXEC:    w_next_state = R_WB;
            I_EXEC:    w_next_state = I_WB;
            MEM_ADDR:  w_next_state = (r_op_q == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  w_next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WRITE: w_next_state = mem_ready ? FETCH : MEM_WRITE;
            R_WB, I_WB, MEM_WB, BRANCH, JUMP, ILLEGAL:
                       w_next_state = FETCH;
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_op_q  <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE)
                r_op_q <= OP;
        end
    end

    mc_output_decode u_output_decode (
        .i_state      (r_state),
        .i_op_q       (r_op_q),
        .i_mem_ready  (mem_ready),
        .o_pc_write   (PCWrite),
        .o_branch_eq  (BranchEQ),
        .o_branch_ne  (BranchNE),
        .o_iord       (IorD),
        .o_mem_read   (MemRead),
        .o_mem_write  (MemWrite),
        .o_ir_write   (IRWrite),
        .o_mem_to_reg (MemtoReg),
        .o_reg_dst    (RegDst),
        .o_reg_write  (RegWrite),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_alu_op     (ALUOp),
        .o_pc_source  (PCSource),
        .o_illegal_op (illegal_op)
    );

    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;
    import multicycle_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic       mem_ready;
    logic       PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0] MemtoReg, RegDst;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic [3:0] state_dbg;
    logic [21:0] w_ctl;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.OP_W(6), .ALUOP_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .OP         (OP),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .BranchEQ   (BranchEQ),
        .BranchNE   (BranchNE),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .illegal_op (illegal_op),
        .state_dbg  (state_dbg)
    );

    assign w_ctl = {PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Field order: pcw beq bne iord mr mw irw m2r rd rw sa sb aop pcs ill
    function automatic logic [21:0] mk(input int pcw, input int beq, input int bne, input int iord,
                                       input int mr, input int mw, input int irw, input int m2r,
                                       input int rd, input int rw, input int sa, input int sb,
                                       input int aop, input int pcs, input int ill);
        return {pcw[0], beq[0], bne[0], iord[0], mr[0], mw[0], irw[0], m2r[1:0], rd[1:0],
                rw[0], sa[0], sb[1:0], aop[3:0], pcs[1:0], ill[0]};
    endfunction

    task automatic expect_state(input string tag, input logic [3:0] exp_st, input logic [21:0] exp_ctl);
        check({tag, "_state"}, {28'b0, state_dbg}, {28'b0, exp_st});
        check({tag, "_ctl"}, {10'b0, w_ctl}, {10'b0, exp_ctl});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic [5:0] op, input logic rdy, input string tag,
                       input logic [3:0] exp_st, input logic [21:0] exp_ctl);
        OP        = op;
        mem_ready = rdy;
        #1;
        expect_state(tag, exp_st, exp_ctl);
        tick();
    endtask

    logic [21:0] c_zero, c_f_rdy, c_f_wait, c_dec;

    initial begin
        c_zero   = '0;
        c_f_rdy  = mk(1,0,0,0,1,0,1,0,0,0,0,1,4'b0100,0,0);
        c_f_wait = mk(0,0,0,0,1,0,0,0,0,0,0,1,4'b0100,0,0);
        c_dec    = mk(0,0,0,0,0,0,0,0,0,0,0,3,4'b0100,0,0);

        reset     = 1'b0;
        OP        = 6'h00;
        mem_ready = 1'b1;
        tick();
        expect_state("reset", IDLE, c_zero);
        reset = 1'b1;
        cyc(6'h00, 1'b1, "idle", IDLE, c_zero);

        // R-type; OP goes junk after DECODE.
        cyc(6'h00, 1'b1, "r_fetch", FETCH, c_f_rdy);
        cyc(6'h00, 1'b1, "r_dec",   DECODE, c_dec);
        cyc(6'h3F, 1'b1, "r_exec",  R_EXEC, mk(0,0,0,0,0,0,0,0,0,0,1,0,4'b1111,0,0));
        cyc(6'h3F, 1'b1, "r_wb",    R_WB,   mk(0,0,0,0,0,0,0,0,1,1,0,0,4'b0000,0,0));

        // ORI; live OP changed to 0 after DECODE so ALUOp must come from op_q.
        cyc(6'h0D, 1'b1, "ori_fetch", FETCH, c_f_rdy);
        cyc(6'h0D, 1'b1, "ori_dec",   DECODE, c_dec);
        cyc(6'h00, 1'b1, "ori_exec",  I_EXEC, mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0101,0,0));
        cyc(6'h00, 1'b1, "ori_wb",    I_WB,   mk(0,0,0,0,0,0,0,0,0,1,0,0,4'b0000,0,0));

        // LUI
        cyc(6'h0F, 1'b1, "lui_fetch", FETCH, c_f_rdy);
        cyc(6'h0F, 1'b1, "lui_dec",   DECODE, c_dec);
        cyc(6'h0F, 1'b1, "lui_exec",  I_EXEC, mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0110,0,0));
        cyc(6'h0F, 1'b1, "lui_wb",    I_WB,   mk(0,0,0,0,0,0,0,0,0,1,0,0,4'b0000,0,0));

        // LW with a fetch wait and two MEM_READ waits; mem_ready=0 in MEM_ADDR is ignored.
        cyc(6'h23, 1'b0, "lw_fwait", FETCH, c_f_wait);
        cyc(6'h23, 1'b1, "lw_fetch", FETCH, c_f_rdy);
        cyc(6'h23, 1'b1, "lw_dec",   DECODE, c_dec);
        cyc(6'h23, 1'b0, "lw_addr",  MEM_ADDR, mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0001,0,0));
        cyc(6'h23, 1'b0, "lw_rd0",   MEM_READ, mk(0,0,0,1,1,0,0,0,0,0,0,0,4'b0000,0,0));
        cyc(6'h23, 1'b0, "lw_rd1",   MEM_READ, mk(0,0,0,1,1,0,0,0,0,0,0,0,4'b0000,0,0));
        cyc(6'h23, 1'b1, "lw_rd2",   MEM_READ, mk(0,0,0,1,1,0,0,0,0,0,0,0,4'b0000,0,0));
        cyc(6'h23, 1'b1, "lw_wb",    MEM_WB,   mk(0,0,0,0,0,0,0,1,0,1,0,0,4'b0000,0,0));

        // SW, zero wait
        cyc(6'h2B, 1'b1, "sw_fetch", FETCH, c_f_rdy);
        cyc(6'h2B, 1'b1, "sw_dec",   DECODE, c_dec);
        cyc(6'h2B, 1'b1, "sw_addr",  MEM_ADDR,  mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0010,0,0));
        cyc(6'h2B, 1'b1, "sw_wr",    MEM_WRITE, mk(0,0,0,1,0,1,0,0,0,0,0,0,4'b0000,0,0));

        // BEQ, BNE
        cyc(6'h04, 1'b1, "beq_fetch", FETCH, c_f_rdy);
        cyc(6'h04, 1'b1, "beq_dec",   DECODE, c_dec);
        cyc(6'h04, 1'b1, "beq_br",    BRANCH, mk(0,1,0,0,0,0,0,0,0,0,1,0,4'b0011,1,0));
        cyc(6'h05, 1'b1, "bne_fetch", FETCH, c_f_rdy);
        cyc(6'h05, 1'b1, "bne_dec",   DECODE, c_dec);
        cyc(6'h05, 1'b1, "bne_br",    BRANCH, mk(0,0,1,0,0,0,0,0,0,0,1,0,4'b0011,1,0));

        // J, JAL
        cyc(6'h02, 1'b1, "j_fetch",   FETCH, c_f_rdy);
        cyc(6'h02, 1'b1, "j_dec",     DECODE, c_dec);
        cyc(6'h02, 1'b1, "j_jump",    JUMP, mk(1,0,0,0,0,0,0,0,0,0,0,0,4'b0000,2,0));
        cyc(6'h03, 1'b1, "jal_fetch", FETCH, c_f_rdy);
        cyc(6'h03, 1'b1, "jal_dec",   DECODE, c_dec);
        cyc(6'h03, 1'b1, "jal_jump",  JUMP, mk(1,0,0,0,0,0,0,2,2,1,0,0,4'b0000,2,0));

        // Illegal opcode: single-cycle pulse, then FETCH
        cyc(6'h3F, 1'b1, "ill_fetch", FETCH, c_f_rdy);
        cyc(6'h3F, 1'b1, "ill_dec",   DECODE, c_dec);
        cyc(6'h3F, 1'b1, "ill_pulse", ILLEGAL, mk(0,0,0,0,0,0,0,0,0,0,0,0,4'b0000,0,1));
        cyc(6'h3F, 1'b0, "ill_after", FETCH, c_f_wait);

        // Reset during a MEM_WRITE wait
        cyc(6'h2B, 1'b1, "swr_fetch", FETCH, c_f_rdy);
        cyc(6'h2B, 1'b1, "swr_dec",   DECODE, c_dec);
        cyc(6'h2B, 1'b0, "swr_addr",  MEM_ADDR,  mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0010,0,0));
        cyc(6'h2B, 1'b0, "swr_wait0", MEM_WRITE, mk(0,0,0,1,0,1,0,0,0,0,0,0,4'b0000,0,0));
        #1;
        expect_state("swr_wait1", MEM_WRITE, mk(0,0,0,1,0,1,0,0,0,0,0,0,4'b0000,0,0));
        reset = 1'b0;
        #1;
        expect_state("rst_mid", IDLE, c_zero);
        check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        tick();
        expect_state("rst_hold", IDLE, c_zero);
        reset = 1'b1;
        cyc(6'h2B, 1'b1, "rst_idle",  IDLE, c_zero);
        cyc(6'h2B, 1'b1, "rst_fetch", FETCH, c_f_rdy);
        cyc(6'h2B, 1'b1, "rst_dec",   DECODE, c_dec);
        cyc(6'h2B, 1'b1, "rst_addr",  MEM_ADDR, mk(0,0,0,0,0,0,0,0,0,0,1,2,4'b0010,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
